// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the registered multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_LUI   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_SLT   = 4'd10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // True for the only opcode that occupies the unit for more than one cycle.
  function automatic logic is_multi_cycle(input logic [3:0] op);
    return (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/alu_mult_seq.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle,
// LSB first. The product register starts with the multiplier in its low
// half; each step adds the multiplicand into the high half and shifts right.
module alu_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;

  // One shift-add step; the carry out of the add lands in the top bit.
  always_comb begin
    w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
           + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    w_step = {w_sum, r_prod[WIDTH-1:1]};
  end

  // The value presented is the post-step product, so it is complete on the
  // cycle where the counter reaches zero.
  assign product = w_step;
  assign last    = r_run & (r_cnt == {CNT_W{1'b0}});

  // Operand latch, step counter and partial-product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand <= {WIDTH{1'b0}};
      r_prod  <= {(2*WIDTH){1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_run   <= 1'b0;
    end else if (load) begin
      r_mcand <= A;
      r_prod  <= {{WIDTH{1'b0}}, B};
      r_cnt   <= CNT_W'(WIDTH - 1);
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_prod <= w_step;
      if (r_cnt == {CNT_W{1'b0}}) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else begin
      r_prod <= r_prod;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered MIPS-style ALU with a start/busy/done handshake. Single-cycle
// operations finish one clock after start; MULTU runs WIDTH cycles in the
// iterative multiplier while busy is high.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         ALUOperation,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               busy,
  output logic               done,
  output logic               Zero,
  output logic [WIDTH-1:0]   ALUResult,
  output logic [WIDTH-1:0]   ResultHi
);

  alu_state_e         r_state;
  alu_state_e         w_state_next;
  logic               w_load;
  logic               w_single;
  logic               w_finish;
  logic [WIDTH-1:0]   w_comb;
  logic [2*WIDTH-1:0] w_product;
  logic               w_last;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_zero;
  logic               r_done;

  alu_mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .A       (A),
    .B       (B),
    .product (w_product),
    .last    (w_last)
  );

  // Single-cycle result; undefined opcodes yield zero.
  always_comb begin
    w_comb = {WIDTH{1'b0}};
    case (ALUOperation)
      OP_AND:  w_comb = A & B;
      OP_OR:   w_comb = A | B;
      OP_NOR:  w_comb = ~(A | B);
      OP_ADD:  w_comb = A + B;
      OP_SUB:  w_comb = A - B;
      OP_LUI:  w_comb = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  w_comb = A << Shamt;
      OP_SRL:  w_comb = A >> Shamt;
      OP_SRA:  w_comb = $signed(A) >>> Shamt;
      OP_SLT:  w_comb = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: w_comb = {WIDTH{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and per-cycle control strobes; start is ignored while in MUL.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_single     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (is_multi_cycle(ALUOperation)) begin
            w_load       = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_single     = 1'b1;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_MUL;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result registers update only on a completion; done pulses with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_zero      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_single | w_finish;
      if (w_single) begin
        r_result    <= w_comb;
        r_result_hi <= {WIDTH{1'b0}};
        r_zero      <= (w_comb == {WIDTH{1'b0}});
      end else if (w_finish) begin
        r_result    <= w_product[WIDTH-1:0];
        r_result_hi <= w_product[2*WIDTH-1:WIDTH];
        r_zero      <= (w_product[WIDTH-1:0] == {WIDTH{1'b0}});
      end else begin
        r_result    <= r_result;
        r_result_hi <= r_result_hi;
        r_zero      <= r_zero;
      end
    end
  end

  assign busy      = (r_state == ST_MUL);
  assign done      = r_done;
  assign Zero      = r_zero;
  assign ALUResult = r_result;
  assign ResultHi  = r_result_hi;

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the single-cycle MIPS ALU. It adds SRA, SLT and an iterative unsigned multiply, with a start/busy/done handshake. Single-cycle operations complete one clock after `start`; MULTU occupies the unit for WIDTH cycles. It sits in the EX stage, or behind the multi-cycle control FSM, which stalls on `busy`.

## Interface
- `WIDTH`, default 32: datapath width. Must be even and ≥ 4.
- `SHAMT_W` is a derived localparam, `$clog2(WIDTH)`. It is not overridable.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launches an operation. Sampled only when `busy`=0.
- `ALUOperation`  in  4  opcode.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `Shamt`  in  SHAMT_W  shift amount.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when the result registers update.
- `Zero`  out  1  registered; high when `ALUResult` == 0.
- `ALUResult`  out  WIDTH  registered result; the low word for MULTU.
- `ResultHi`  out  WIDTH  high word of the MULTU product. 0 after any other operation.

## Operation
Opcodes:
- 0 AND: A & B.
- 1 OR: A | B.
- 2 NOR: ~(A | B).
- 3 ADD: A + B, modulo 2^WIDTH, no overflow flag.
- 4 SUB: A − B, modulo 2^WIDTH.
- 5 LUI: {B[WIDTH/2-1:0], WIDTH/2 zeros}.
- 6 SLL: A << Shamt.
- 7 SRL: A >> Shamt, logical.
- 8 SRA: A >>> Shamt, sign-filled.
- 9 MULTU: unsigned A × B, 2·WIDTH-bit product split across {`ResultHi`, `ALUResult`}.
- 10 SLT: 1 if $signed(A) < $signed(B), else 0.
- 11–15: `ALUResult` = 0, completed as a single-cycle operation.

Shifts use `Shamt` only, never B.

State machine (states IDLE, MUL):
- IDLE, `start`=1, opcode ≠ 9: compute combinationally. On that edge, register `ALUResult`, `Zero`, and `ResultHi`=0, and pulse `done`. Stay in IDLE.
- IDLE, `start`=1, opcode = 9: latch A and B, load the cycle counter with WIDTH−1, clear the accumulator, go to MUL.
- MUL: each cycle performs one shift-add step, LSB-first on the multiplier, and decrements the counter.
  - When the counter is 0: register the 2·WIDTH-bit product, update `Zero` from the low word, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored. It is not queued.
- Input changes during MUL have no effect, because operands are latched.
- Result outputs hold their values between completions.

Reset (any state, including mid-multiply):
- State goes to IDLE and the counter to 0.
- `busy`=0, `done`=0, `ALUResult`=0, `ResultHi`=0, `Zero`=1.
- An aborted multiply produces no `done`.

## Timing
- Single-cycle operations: `start` sampled at edge N; results and `done` valid after edge N, i.e. latency 1. Back-to-back `start` every cycle gives throughput 1 per cycle.
- MULTU: `start` sampled at edge N. `busy`=1 after edges N … N+WIDTH−1. After edge N+WIDTH, `busy`=0 and results and `done` are valid. Latency is WIDTH cycles.
- In the `done` cycle of a multiply, `busy`=0, so a new `start` is accepted in that same cycle.
- `done` is never asserted for two consecutive cycles by one operation.
- `reset` wins over `start` in the same cycle.

## Structure
- Package `alu_pkg`:
  - 4-bit opcode localparams: AND, OR, NOR, ADD, SUB, LUI, SLL, SRL, SRA, MULTU, SLT.
  - FSM state typedef/encoding (IDLE, MUL).
- Sub-module `alu_mult_seq`, the iterative shift-add multiplier:
  - inputs: `clk`, `reset`, `load`, `A`, `B`
  - outputs: `product[2·WIDTH-1:0]`, `last`
  - The top level owns the FSM, the combinational operations and the output registers.

## Test plan
All scenarios use WIDTH=32.
- **Reset:** assert `reset` 2 cycles → `ALUResult`=0, `ResultHi`=0, `Zero`=1, `busy`=0, `done`=0.
- **ADD wrap:** ADD A=0xFFFFFFFF, B=1, `start` 1 cycle → next cycle `ALUResult`=0, `Zero`=1, `done`=1 for exactly one cycle. Then SUB A=5, B=7 → 0xFFFFFFFE, `Zero`=0.
- **Shifts, LUI, SLT:**
  - A=0x80000000, Shamt=4: SRA → 0xF8000000; SRL → 0x08000000; SLL with Shamt=1 → 0.
  - LUI B=0x00001234 → 0x12340000.
  - SLT A=0xFFFFFFFF, B=1 → 1.
- **MULTU:** A=0xFFFFFFFF, B=2 → `busy` high exactly 32 cycles. `done` at cycle 32 with `ALUResult`=0xFFFFFFFE, `ResultHi`=0x00000001. `start` pulses (ADD) issued during `busy` are ignored: no extra `done`, result unchanged.
- **Back-to-back:** MULTU A=3, B=5 followed by ADD A=1, B=1 on the `done` cycle → product 15 / `ResultHi` 0, then 2 one cycle later, `ResultHi`=0.
- **Reset mid-multiply:** `reset` at cycle 10 of a MULTU → `busy`=0, no `done` ever fires for that operation, outputs at reset values. A following OR A=0xF0, B=0x0F → 0xFF.
